// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-add signed multiplier control slice.
package mult_pkg;
    localparam int MULT_WIDTH = 8;
    localparam int CNT_W      = $clog2(MULT_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced level input; the registered copy is cleared by reset.
module rise_detect (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/multiplier_control.sv
// Control FSM for the 8-bit shift-add signed multiplier: load/clear, XA clear,
// WIDTH add-or-subtract/shift iterations, then a one-cycle Done in HOLD.
module multiplier_control
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Reset_Load_Clear,
    input  logic Run,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearXA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    mult_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          run_rise;

    // Run is registered every cycle, so an edge seen outside IDLE is consumed.
    rise_detect u_run_rise (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .d       (Run),
        .rise    (run_rise)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Clr_Ld    = 1'b0;
        ClearXA   = 1'b0;
        Add       = 1'b0;
        Sub       = 1'b0;
        Shift     = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;

        case (state)
            IDLE: begin
                Clr_Ld = Reset_Load_Clear;
                if (run_rise && !Reset_Load_Clear) state_nxt = CLEAR;
            end
            CLEAR: begin
                ClearXA   = 1'b1;
                Busy      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ADD;
            end
            ADD: begin
                // The final multiplier bit carries negative weight in two's complement.
                Busy      = 1'b1;
                Add       = M & (cnt != LAST);
                Sub       = M & (cnt == LAST);
                state_nxt = SHIFT;
            end
            SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = ADD;
                end
            end
            HOLD: begin
                // cnt arrives at LAST and is zeroed after one cycle, limiting Done to one pulse.
                Done    = (cnt == LAST);
                cnt_nxt = '0;
                if (!Run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (!Reset_n) begin
            Clr_Ld  = 1'b0;
            ClearXA = 1'b0;
            Add     = 1'b0;
            Sub     = 1'b0;
            Shift   = 1'b0;
            Busy    = 1'b0;
            Done    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control with a behavioural step model, a plant datapath and product checks.
module tb_multiplier_control;
    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Reset_Load_Clear = 1'b1;
    logic Run = 1'b1;
    logic M;
    logic Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done;

    int checks = 0;
    int errors = 0;

    multiplier_control #(.WIDTH(W)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Reset_Load_Clear (Reset_Load_Clear),
        .Run              (Run),
        .M                (M),
        .Clr_Ld           (Clr_Ld),
        .ClearXA          (ClearXA),
        .Add              (Add),
        .Sub              (Sub),
        .Shift            (Shift),
        .Busy             (Busy),
        .Done             (Done)
    );

    always #5 Clk = ~Clk;

    // Plant datapath: X, A, B registers and 9-bit adder driven by the DUT strobes.
    logic [7:0] SW = 8'h00;
    logic       X_dp = 1'b0;
    logic [7:0] A_dp = 8'h00;
    logic [7:0] B_dp = 8'h00;
    logic [8:0] xa_sum, xa_dif;
    assign xa_sum = {A_dp[7], A_dp} + {SW[7], SW};
    assign xa_dif = {A_dp[7], A_dp} - {SW[7], SW};
    assign M = B_dp[0];

    always @(posedge Clk) begin
        if (Clr_Ld) begin
            X_dp <= 1'b0; A_dp <= 8'h00; B_dp <= SW;
        end else if (ClearXA) begin
            X_dp <= 1'b0; A_dp <= 8'h00;
        end else if (Add) begin
            X_dp <= xa_sum[8]; A_dp <= xa_sum[7:0];
        end else if (Sub) begin
            X_dp <= xa_dif[8]; A_dp <= xa_dif[7:0];
        end else if (Shift) begin
            A_dp <= {X_dp, A_dp[7:1]};
            B_dp <= {A_dp[0], B_dp[7:1]};
        end
    end

    // Behavioural model: mode 0 idle, 1 busy (step 0 = clear, odd = add, even = shift), 2 hold.
    int  mode = 0;
    int  step = 0;
    bit  first_hold = 1'b0;
    bit  prev_run = 1'b0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode <= 0; step <= 0; first_hold <= 1'b0; prev_run <= 1'b0;
        end else begin
            prev_run <= Run;
            case (mode)
                0: if (Run && !prev_run && !Reset_Load_Clear) begin mode <= 1; step <= 0; end
                1: if (step == 2 * W) begin mode <= 2; first_hold <= 1'b1; end
                   else step <= step + 1;
                default: begin first_hold <= 1'b0; if (!Run) mode <= 0; end
            endcase
        end
    end

    int cyc = 0, clr_cyc = 0;
    int adds = 0, subs = 0, shifts = 0, dones = 0, clrld_cnt = 0;
    logic [15:0] exp_prod = 16'h0;
    logic [6:0]  exp_o, act_o;

    always @(negedge Clk) begin
        exp_o = 7'b0;
        if (Reset_n) begin
            case (mode)
                0: exp_o[6] = Reset_Load_Clear;
                1: begin
                    exp_o[1] = 1'b1;
                    if (step == 0) exp_o[5] = 1'b1;
                    else if (step % 2 == 1) begin
                        exp_o[4] = M && ((step - 1) / 2 < W - 1);
                        exp_o[3] = M && ((step - 1) / 2 == W - 1);
                    end else exp_o[2] = 1'b1;
                end
                default: exp_o[0] = first_hold;
            endcase
        end
        act_o = {Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL outputs cyc=%0d got %b expected %b (Clr_Ld ClearXA Add Sub Shift Busy Done)",
                     cyc, act_o, exp_o);
        end
        cyc++;
        if (Clr_Ld) clrld_cnt++;
        if (ClearXA) begin
            adds = 0; subs = 0; shifts = 0; clr_cyc = cyc;
            exp_prod = 16'(int'($signed(SW)) * int'($signed(B_dp)));
        end
        if (Add) adds++;
        if (Sub) subs++;
        if (Shift) shifts++;
        if (Done) begin
            dones++;
            checks++;
            if (cyc - clr_cyc != 2 * W + 1) begin
                errors++;
                $display("FAIL latency got %0d expected %0d", cyc - clr_cyc, 2 * W + 1);
            end
            checks++;
            if ({A_dp, B_dp} !== exp_prod) begin
                errors++;
                $display("FAIL product got %h expected %h", {A_dp, B_dp}, exp_prod);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic expect_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk); #1;
            if (Done) seen = 1'b1;
        end
        expect_eq({name, "_done_seen"}, int'(seen), 1);
    endtask

    int d0, c0;

    initial begin
        // 1: reset with Run and Reset_Load_Clear high
        tick(2);
        expect_eq("reset_outputs", int'({Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done}), 0);
        tick(1);
        Reset_n = 1'b1;
        tick(1);
        Reset_Load_Clear = 1'b0;
        tick(4);
        expect_eq("post_reset_no_start", int'(Busy), 0);
        Run = 1'b0;
        tick(2);

        // 2: load B = 0x07 over four held cycles
        SW = 8'h07;
        c0 = clrld_cnt;
        Reset_Load_Clear = 1'b1;
        tick(4);
        Reset_Load_Clear = 1'b0;
        tick(2);
        expect_eq("clr_ld_cycles", clrld_cnt - c0, 4);

        // 3: S = 0xC5 (-59), B = 7, Run held for 40 cycles
        SW = 8'hC5;
        d0 = dones;
        Run = 1'b1;
        wait_done("run_c5x07");
        expect_eq("prod_c5x07", int'({A_dp, B_dp}), 16'hFE63);
        expect_eq("adds_c5x07", adds, 3);
        expect_eq("subs_c5x07", subs, 0);
        expect_eq("shifts_c5x07", shifts, W);
        tick(22);
        expect_eq("held_run_one_done", dones - d0, 1);
        Run = 1'b0;
        tick(2);

        // 4: B = 0x80, S = 7, Reset_Load_Clear raised mid-run
        SW = 8'h80;
        Reset_Load_Clear = 1'b1;
        tick(1);
        Reset_Load_Clear = 1'b0;
        SW = 8'h07;
        tick(1);
        Run = 1'b1;
        tick(6);
        Reset_Load_Clear = 1'b1;
        tick(3);
        Reset_Load_Clear = 1'b0;
        wait_done("run_80x07");
        expect_eq("prod_80x07", int'({A_dp, B_dp}), 16'hFC80);
        expect_eq("subs_80x07", subs, 1);
        expect_eq("adds_80x07", adds, 0);
        Run = 1'b0;
        tick(2);

        // 5: Run re-pressed during Busy is ignored; release and press starts a new run
        SW = 8'h13;
        d0 = dones;
        Run = 1'b1;
        tick(4);
        Run = 1'b0;
        tick(2);
        Run = 1'b1;
        tick(40);
        expect_eq("repress_one_done", dones - d0, 1);
        Run = 1'b0;
        tick(2);
        Run = 1'b1;
        wait_done("second_run");
        expect_eq("second_run_dones", dones - d0, 2);
        Run = 1'b0;
        tick(2);

        // 6: Run edge together with Reset_Load_Clear in IDLE: load only
        c0 = clrld_cnt;
        Reset_Load_Clear = 1'b1;
        Run = 1'b1;
        tick(3);
        Reset_Load_Clear = 1'b0;
        tick(3);
        expect_eq("load_wins_busy", int'(Busy), 0);
        expect_eq("load_wins_clrld", clrld_cnt - c0, 3);
        Run = 1'b0;
        tick(2);

        // Reset_n mid-operation forces outputs low immediately, then a clean run
        Run = 1'b1;
        tick(6);
        @(negedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        expect_eq("async_reset_outputs", int'({Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done}), 0);
        Run = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        SW = 8'hF6;
        tick(1);
        Run = 1'b1;
        wait_done("after_reset_run");
        Run = 1'b0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
